// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm event generator.
package alarm_pkg;

    localparam int unsigned HH_W = 5;
    localparam int unsigned MM_W = 6;
    localparam int unsigned SS_W = 6;

    localparam int unsigned DEF_RING_TIMEOUT_S = 60;
    localparam int unsigned DEF_SNOOZE_S       = 300;
    localparam int unsigned DEF_MAX_SNOOZE     = 3;

    typedef enum logic [1:0] {
        IDLE,
        RINGING,
        SNOOZE
    } alarm_state_t;

    // Counter width able to hold the larger of the two tick budgets.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable, tick-enabled down counter that saturates at zero.
module tick_down_counter #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alarm_trigger.sv
// Alarm sequencer: match detection, ringing, snooze and auto-timeout.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int unsigned RING_TIMEOUT_S = DEF_RING_TIMEOUT_S,
    parameter int unsigned SNOOZE_S       = DEF_SNOOZE_S,
    parameter int unsigned MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick_1hz,
    input  logic [HH_W-1:0] cur_hh,
    input  logic [MM_W-1:0] cur_mm,
    input  logic [SS_W-1:0] cur_ss,
    input  logic [HH_W-1:0] alarm_hh,
    input  logic [MM_W-1:0] alarm_mm,
    input  logic            alarm_en,
    input  logic            dismiss,
    input  logic            snooze_btn,
    output logic            alarm_signal,
    output logic            snoozing,
    output logic [1:0]      snooze_left
);

    localparam int unsigned    CW          = cnt_width(RING_TIMEOUT_S, SNOOZE_S);
    localparam logic [CW-1:0]  RING_LOAD   = CW'(RING_TIMEOUT_S - 1);
    localparam logic [CW-1:0]  SNOOZE_LOAD = CW'(SNOOZE_S - 1);
    localparam logic [1:0]     LEFT_INIT   = 2'(MAX_SNOOZE);

    alarm_state_t state, state_next;
    logic         match;
    logic         ring_load, ring_tick, ring_zero;
    logic         snz_load, snz_tick, snz_zero;
    logic [1:0]   left_next;

    assign match = tick_1hz & alarm_en & ~dismiss &
                   (cur_hh == alarm_hh) & (cur_mm == alarm_mm) & (cur_ss == '0);

    tick_down_counter #(.W(CW)) u_ring_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ring_load),
        .load_val (RING_LOAD),
        .tick     (ring_tick),
        .zero     (ring_zero)
    );

    tick_down_counter #(.W(CW)) u_snooze_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (snz_load),
        .load_val (SNOOZE_LOAD),
        .tick     (snz_tick),
        .zero     (snz_zero)
    );

    // Priority: dismiss/disable, then snooze, then timeout, then decrement.
    always_comb begin
        state_next = state;
        ring_load  = 1'b0;
        ring_tick  = 1'b0;
        snz_load   = 1'b0;
        snz_tick   = 1'b0;
        left_next  = snooze_left;
        if (dismiss || !alarm_en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (match) begin
                        state_next = RINGING;
                        ring_load  = 1'b1;
                        left_next  = LEFT_INIT;
                    end
                end
                RINGING: begin
                    if (snooze_btn && (snooze_left != 2'd0)) begin
                        state_next = SNOOZE;
                        snz_load   = 1'b1;
                        left_next  = snooze_left - 2'd1;
                    end else if (tick_1hz) begin
                        if (ring_zero) state_next = IDLE;
                        else           ring_tick  = 1'b1;
                    end
                end
                SNOOZE: begin
                    if (tick_1hz) begin
                        if (snz_zero) begin
                            state_next = RINGING;
                            ring_load  = 1'b1;
                        end else begin
                            snz_tick = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next-state decode so they align with state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            alarm_signal <= 1'b0;
            snoozing     <= 1'b0;
            snooze_left  <= LEFT_INIT;
        end else begin
            state        <= state_next;
            alarm_signal <= (state_next == RINGING);
            snoozing     <= (state_next == SNOOZE);
            snooze_left  <= left_next;
        end
    end

endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger against a tick-budget reference model.
`timescale 1ns/1ps
module tb_alarm_trigger;

    localparam int R  = 5;
    localparam int S  = 3;
    localparam int MX = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic [4:0] cur_hh, alarm_hh;
    logic [5:0] cur_mm, cur_ss, alarm_mm;
    logic       alarm_en, dismiss, snooze_btn;
    logic       alarm_signal, snoozing;
    logic [1:0] snooze_left;

    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;

    int th, tm, ts;

    // Model: remaining ring ticks, remaining silent ticks, snoozes left.
    int m_ring_rem  = 0;
    int m_quiet_rem = 0;
    int m_left      = MX;

    alarm_trigger #(
        .RING_TIMEOUT_S (R),
        .SNOOZE_S       (S),
        .MAX_SNOOZE     (MX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick_1hz     (tick_1hz),
        .cur_hh       (cur_hh),
        .cur_mm       (cur_mm),
        .cur_ss       (cur_ss),
        .alarm_hh     (alarm_hh),
        .alarm_mm     (alarm_mm),
        .alarm_en     (alarm_en),
        .dismiss      (dismiss),
        .snooze_btn   (snooze_btn),
        .alarm_signal (alarm_signal),
        .snoozing     (snoozing),
        .snooze_left  (snooze_left)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ring_rem  = 0;
            m_quiet_rem = 0;
            m_left      = MX;
        end else if (dismiss || !alarm_en) begin
            m_ring_rem  = 0;
            m_quiet_rem = 0;
        end else if (m_ring_rem > 0) begin
            if (snooze_btn && m_left > 0) begin
                m_ring_rem  = 0;
                m_quiet_rem = S;
                m_left      = m_left - 1;
            end else if (tick_1hz) begin
                m_ring_rem = m_ring_rem - 1;
            end
        end else if (m_quiet_rem > 0) begin
            if (tick_1hz) begin
                m_quiet_rem = m_quiet_rem - 1;
                if (m_quiet_rem == 0) m_ring_rem = R;
            end
        end else if (tick_1hz && cur_ss == 0 && cur_hh == alarm_hh && cur_mm == alarm_mm) begin
            m_ring_rem = R;
            m_left     = MX;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model_alarm_signal", {31'd0, alarm_signal}, (m_ring_rem > 0) ? 32'd1 : 32'd0);
            check("model_snoozing",     {31'd0, snoozing},     (m_quiet_rem > 0) ? 32'd1 : 32'd0);
            check("model_snooze_left",  {30'd0, snooze_left},  32'(m_left));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_time(input int h, input int m, input int s);
        th = h; tm = m; ts = s;
        cur_hh = 5'(th); cur_mm = 6'(tm); cur_ss = 6'(ts);
    endtask

    // Advance the clock by one second, pulse the tick, then one quiet cycle.
    task automatic step();
        ts++;
        if (ts == 60) begin ts = 0; tm++; end
        if (tm == 60) begin tm = 0; th++; end
        if (th == 24) th = 0;
        cur_hh = 5'(th); cur_mm = 6'(tm); cur_ss = 6'(ts);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_snooze();
        snooze_btn = 1'b1;
        @(negedge clk);
        snooze_btn = 1'b0;
    endtask

    task automatic trigger();
        set_time(7, 29, 59);
        step();
    endtask

    initial begin
        rst_n = 1'b0; tick_1hz = 1'b0; snooze_btn = 1'b0;
        dismiss = 1'b0; alarm_en = 1'b1;
        alarm_hh = 5'd7; alarm_mm = 6'd30;
        set_time(0, 0, 0);
        @(negedge clk);
        armed = 1'b1;
        @(negedge clk);
        check("reset_alarm_signal", {31'd0, alarm_signal}, 32'd0);
        check("reset_snoozing",     {31'd0, snoozing},     32'd0);
        check("reset_snooze_left",  {30'd0, snooze_left},  32'd2);
        rst_n = 1'b1;

        // Basic ring and timeout.
        set_time(7, 29, 58);
        step();
        check("pre_match_quiet", {31'd0, alarm_signal}, 32'd0);
        step();
        check("ring_on_match", {31'd0, alarm_signal}, 32'd1);
        repeat (R - 1) step();
        check("ring_before_timeout", {31'd0, alarm_signal}, 32'd1);
        step();
        check("ring_timeout", {31'd0, alarm_signal}, 32'd0);

        // Snooze sequence and exhausted snooze.
        trigger();
        pulse_snooze();
        check("snz1_alarm", {31'd0, alarm_signal}, 32'd0);
        check("snz1_snoozing", {31'd0, snoozing}, 32'd1);
        check("snz1_left", {30'd0, snooze_left}, 32'd1);
        repeat (S - 1) step();
        check("snz1_still_quiet", {31'd0, snoozing}, 32'd1);
        step();
        check("snz1_rering", {31'd0, alarm_signal}, 32'd1);
        check("snz1_rering_snz", {31'd0, snoozing}, 32'd0);
        pulse_snooze();
        check("snz2_left", {30'd0, snooze_left}, 32'd0);
        repeat (S) step();
        check("snz2_rering", {31'd0, alarm_signal}, 32'd1);
        pulse_snooze();
        check("snz3_ignored", {31'd0, alarm_signal}, 32'd1);
        check("snz3_left", {30'd0, snooze_left}, 32'd0);
        repeat (R - 1) step();
        check("snz3_still_ring", {31'd0, alarm_signal}, 32'd1);
        step();
        check("snz3_timeout", {31'd0, alarm_signal}, 32'd0);

        // Dismiss blocks a match; dismiss beats snooze.
        dismiss = 1'b1;
        set_time(7, 29, 58);
        step();
        step();
        check("dismiss_blocks", {31'd0, alarm_signal}, 32'd0);
        dismiss = 1'b0;
        step();
        check("no_late_trigger", {31'd0, alarm_signal}, 32'd0);
        trigger();
        check("retrigger", {31'd0, alarm_signal}, 32'd1);
        dismiss = 1'b1; snooze_btn = 1'b1;
        @(negedge clk);
        dismiss = 1'b0; snooze_btn = 1'b0;
        check("dismiss_vs_snooze_alarm", {31'd0, alarm_signal}, 32'd0);
        check("dismiss_vs_snooze_snz", {31'd0, snoozing}, 32'd0);
        check("dismiss_vs_snooze_left", {30'd0, snooze_left}, 32'd2);

        // Reset in the middle of a snooze.
        trigger();
        pulse_snooze();
        check("pre_reset_snoozing", {31'd0, snoozing}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_alarm", {31'd0, alarm_signal}, 32'd0);
        check("midrst_snoozing", {31'd0, snoozing}, 32'd0);
        check("midrst_left", {30'd0, snooze_left}, 32'd2);
        step();
        check("after_rst_no_ring", {31'd0, alarm_signal}, 32'd0);

        // Disable while ringing, re-enable in same minute.
        trigger();
        alarm_en = 1'b0;
        @(negedge clk);
        check("disable_stops", {31'd0, alarm_signal}, 32'd0);
        alarm_en = 1'b1;
        step();
        step();
        check("reenable_no_ring", {31'd0, alarm_signal}, 32'd0);

        // Randomized traffic around the alarm time.
        repeat (4000) begin
            tick_1hz   = ($urandom_range(0, 3) == 0);
            cur_ss     = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 59));
            cur_hh     = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 23)) : alarm_hh;
            cur_mm     = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(0, 59)) : alarm_mm;
            snooze_btn = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 59) == 0) dismiss = ~dismiss;
            alarm_en   = ($urandom_range(0, 79) != 0);
            rst_n      = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 499) == 0) begin
                alarm_hh = 5'($urandom_range(0, 23));
                alarm_mm = 6'($urandom_range(0, 59));
            end
            @(negedge clk);
        end
        rst_n = 1'b1; tick_1hz = 1'b0; snooze_btn = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
